// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM side of the CPU: data words, RAM status
// encoding and the memory arbiter state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data requests.
// Data wins ties, but a starve counter forces an instruction grant eventually.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output word_t             iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  word_t             dstore,
    output logic              dwait,
    output word_t             dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output word_t             ramstore,
    input  word_t             ramload,
    input  logic [1:0]        ramstate,
    output logic              memerr
);

    localparam int            CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_state_t    state;
    logic [CW-1:0] cnt;
    logic          dreq;
    logic          done;
    logic          starved;

    assign dreq    = dREN | dWEN;
    assign done    = (ramstate == ACCESS) || (ramstate == ERROR);
    assign starved = iREN && (cnt == STARVE_LIM);

    // Every completion or abort returns to IDLE, which gives the mandatory bubble.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            cnt    <= '0;
            memerr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq && !starved) begin
                        state <= DGNT;
                        cnt   <= !iREN ? '0 : ((cnt == STARVE_LIM) ? cnt : cnt + 1'b1);
                    end else if (iREN) begin
                        state <= IGNT;
                        cnt   <= '0;
                    end
                end
                IGNT: begin
                    if (!iREN) begin
                        state <= IDLE;
                    end else if (done) begin
                        state <= IDLE;
                        if (ramstate == ERROR) memerr <= 1'b1;
                    end
                end
                DGNT: begin
                    if (!dreq) begin
                        state <= IDLE;
                    end else if (done) begin
                        state <= IDLE;
                        if (ramstate == ERROR) memerr <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gating on the live enables drops the RAM port in the same cycle as an abort.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state)
            IGNT: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    iwait   = !done;
                end
            end
            DGNT: begin
                if (dreq) begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    dwait    = !done;
                end
            end
            default: ;
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected completions,
// a negedge monitor pops and compares whenever iwait or dwait drops.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int STARVE_MAX = 4;

    logic        CLK    = 1'b0;
    logic        nRST   = 1'b1;
    logic        iREN   = 1'b0;
    logic        dREN   = 1'b0;
    logic        dWEN   = 1'b0;
    logic [31:0] iaddr  = '0;
    logic [31:0] daddr  = '0;
    logic [31:0] dstore = '0;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN, memerr;
    logic [1:0]  ramstate;

    int ram_lat  = 0;
    bit ram_err  = 1'b0;
    int busy_cnt = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_d;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] store;
        bit          chk_load;
        logic [31:0] load;
    } exp_t;

    exp_t sb[$];

    always #5 CLK = ~CLK;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    // RAM model: fixed contents, answers after ram_lat BUSY cycles
    function automatic logic [31:0] ram_model(input logic [31:0] a);
        case (a)
            32'h100: return 32'hDEADBEEF;
            32'h200: return 32'h12345678;
            32'h300: return 32'hCAFEF00D;
            default: return 32'h0;
        endcase
    endfunction

    assign ramload  = ram_model(ramaddr);
    assign ramstate = !(ramREN || ramWEN) ? FREE :
                      (busy_cnt >= ram_lat) ? (ram_err ? ERROR : ACCESS) : BUSY;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST)                                    busy_cnt <= 0;
        else if ((ramREN || ramWEN) && ramstate == BUSY) busy_cnt <= busy_cnt + 1;
        else                                          busy_cnt <= 0;
    end

    always @(negedge CLK) begin : monitor
        exp_t e;
        bit   ok;
        if (nRST && (!iwait || !dwait)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done iwait=%0b dwait=%0b required no completion", iwait, dwait);
            end else begin
                e  = sb.pop_front();
                ok = (e.is_d ? (!dwait && iwait) : (!iwait && dwait)) &&
                     ramREN === e.ren && ramWEN === e.wen &&
                     ramaddr === e.addr && ramstore === e.store &&
                     (!e.chk_load || (e.is_d ? dload : iload) === e.load);
                if (!ok) begin
                    errors++;
                    $display("[TB] FAIL completion actual iw=%0b dw=%0b ren=%0b wen=%0b addr=0x%0h st=0x%0h il=0x%0h dl=0x%0h required data=%0b ren=%0b wen=%0b addr=0x%0h st=0x%0h load=0x%0h",
                             iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload,
                             e.is_d, e.ren, e.wen, e.addr, e.store, e.load);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic i_en, input logic [31:0] i_a, input logic d_ren,
                                 input logic d_wen, input logic [31:0] d_a, input logic [31:0] d_st);
        iREN   = i_en;
        iaddr  = i_a;
        dREN   = d_ren;
        dWEN   = d_wen;
        daddr  = d_a;
        dstore = d_st;
    endtask

    task automatic push_exp(input bit is_d, input bit ren, input bit wen, input logic [31:0] addr,
                            input logic [31:0] store, input bit chk_load, input logic [31:0] load);
        exp_t e;
        e.is_d = is_d; e.ren = ren; e.wen = wen; e.addr = addr;
        e.store = store; e.chk_load = chk_load; e.load = load;
        sb.push_back(e);
    endtask

    task automatic wait_done(input bit is_d, input int max_cycles);
        int n = 0;
        @(negedge CLK);
        while ((is_d ? dwait : iwait) && n < max_cycles) begin
            @(negedge CLK);
            n++;
        end
        if (is_d ? dwait : iwait) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout_%s actual=still_waiting required=done within %0d cycles",
                     is_d ? "dwait" : "iwait", max_cycles);
        end
    endtask

    initial begin
        #2 nRST = 1'b0;
        #1;
        checkOutput("reset_ramREN", 32'(ramREN), 32'd0);
        checkOutput("reset_ramWEN", 32'(ramWEN), 32'd0);
        checkOutput("reset_ramaddr", ramaddr, 32'd0);
        checkOutput("reset_waits", {30'd0, iwait, dwait}, 32'd3);
        checkOutput("reset_memerr", 32'(memerr), 32'd0);
        @(negedge CLK) nRST = 1'b1;

        // Single fetch, RAM answers on the second granted cycle
        ram_lat = 1;
        @(posedge CLK); #1;
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        push_exp(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
        @(negedge CLK);
        checkOutput("t1_cycle0_ramREN", 32'(ramREN), 32'd0);
        @(negedge CLK);
        checkOutput("t1_cycle1_ramREN", 32'(ramREN), 32'd1);
        checkOutput("t1_cycle1_ramaddr", ramaddr, 32'h100);
        checkOutput("t1_cycle1_iwait", 32'(iwait), 32'd1);
        wait_done(1'b0, 10);
        @(posedge CLK); #1;
        @(negedge CLK);
        checkOutput("t1_bubble_ramREN", 32'(ramREN), 32'd0);
        checkOutput("t1_bubble_iwait", 32'(iwait), 32'd1);
        iREN = 1'b0;

        // Simultaneous fetch and write: data first, then fetch after a bubble
        ram_lat = 0;
        @(posedge CLK); #1;
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 32'h55);
        push_exp(1'b1, 1'b0, 1'b1, 32'h200, 32'h55, 1'b0, 32'h0);
        push_exp(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
        wait_done(1'b1, 10);
        @(posedge CLK); #1;
        dWEN = 1'b0;
        @(negedge CLK);
        checkOutput("t2_bubble_ram_en", {30'd0, ramREN, ramWEN}, 32'd0);
        wait_done(1'b0, 10);
        @(posedge CLK); #1;
        iREN = 1'b0;

        // Starvation: four data grants then one fetch, twice
        @(posedge CLK); #1;
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0);
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) push_exp(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
            else            push_exp(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h12345678);
        end
        for (int k = 0; k < 10; k++) wait_done((k % 5 == 4) ? 1'b0 : 1'b1, 6);
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Read and write both high: write wins
        ram_lat = 1;
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'hA5A5A5A5);
        push_exp(1'b1, 1'b0, 1'b1, 32'h300, 32'hA5A5A5A5, 1'b0, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("t4_ramWEN", 32'(ramWEN), 32'd1);
        checkOutput("t4_ramREN", 32'(ramREN), 32'd0);
        checkOutput("t4_dwait_busy", 32'(dwait), 32'd1);
        wait_done(1'b1, 10);
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // ERROR completion sets sticky memerr
        ram_lat = 0;
        ram_err = 1'b1;
        @(posedge CLK); #1;
        checkOutput("t5_memerr_before", 32'(memerr), 32'd0);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        push_exp(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
        wait_done(1'b0, 10);
        checkOutput("t5_memerr_done_cycle", 32'(memerr), 32'd0);
        @(posedge CLK); #1;
        iREN = 1'b0;
        ram_err = 1'b0;
        @(negedge CLK);
        checkOutput("t5_memerr_set", 32'(memerr), 32'd1);
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
        push_exp(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h12345678);
        wait_done(1'b1, 10);
        @(posedge CLK); #1;
        dREN = 1'b0;
        @(negedge CLK);
        checkOutput("t5_memerr_sticky", 32'(memerr), 32'd1);

        // Abort: requester drops its enable while the RAM is busy
        ram_lat = 5;
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("t6_granted_ramREN", 32'(ramREN), 32'd1);
        dREN = 1'b0;
        #1;
        checkOutput("t6_abort_ramREN", 32'(ramREN), 32'd0);
        checkOutput("t6_abort_ramaddr", ramaddr, 32'd0);
        checkOutput("t6_abort_dwait", 32'(dwait), 32'd1);
        repeat (3) @(negedge CLK);
        checkOutput("t6_after_abort_dwait", 32'(dwait), 32'd1);

        // Asynchronous reset in the middle of a busy data write
        @(posedge CLK); #1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'h77);
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("t7_granted_ramWEN", 32'(ramWEN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        checkOutput("t7_rst_ram_en", {30'd0, ramREN, ramWEN}, 32'd0);
        checkOutput("t7_rst_ramaddr", ramaddr, 32'd0);
        checkOutput("t7_rst_ramstore", ramstore, 32'd0);
        checkOutput("t7_rst_waits", {30'd0, iwait, dwait}, 32'd3);
        checkOutput("t7_rst_memerr", 32'(memerr), 32'd0);
        dWEN = 1'b0;
        @(negedge CLK) nRST = 1'b1;
        ram_lat = 0;
        @(posedge CLK); #1;
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        push_exp(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
        wait_done(1'b0, 10);
        @(posedge CLK); #1;
        iREN = 1'b0;

        repeat (3) @(negedge CLK);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
